// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stream controller.
//   LFSR_W        : width of the pseudo-random source
//   LFSR_TAPS     : feedback tap mask (bits 7,6,3,2,1,0)
//   LFSR_ZERO_SUB : value loaded instead of an all-zero seed
//   state_t       : controller state encoding
package sc_pkg;

  localparam int          LFSR_W        = 8;
  localparam logic [7:0]  LFSR_TAPS     = 8'hCF;
  localparam logic [7:0]  LFSR_ZERO_SUB = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit right-shifting LFSR; feedback enters at bit 7.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active HIGH (name kept for codebase consistency)
//   load  : load seed (zero seed is replaced so the register never locks at 0)
//   en    : advance one step
//   seed  : value to load
//   state : current LFSR contents
module sc_lfsr8
  import sc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= LFSR_ZERO_SUB;
    end else if (load) begin
      state <= (seed == '0) ? LFSR_ZERO_SUB : seed;
    end else if (en) begin
      // next[7] is the XOR of the tapped bits; the rest shift down by one.
      state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/sc_stream_ctrl.sv
// Sequences one stochastic-computing evaluation: latches operands and a seed
// on start, drives comparator-generated bitstreams to an external SC circuit
// for LEN cycles, counts ones on its output and reports the count.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active HIGH
//   start     : request a run (sampled only in IDLE)
//   abort     : cancel a run in progress (only acts in RUN)
//   seed      : LFSR seed, latched at start
//   bin_in    : N_IN packed operands, slice i = operand i
//   sc_bits   : stochastic bits to the SC circuit (0 when sc_valid=0)
//   sc_valid  : sc_bits belong to the counted stream
//   sc_out    : SC circuit output, combinational from sc_bits
//   busy      : high in RUN
//   done      : one-cycle pulse, result valid from this cycle on
//   result    : ones counted during the last completed run
//   state_dbg : current controller state
// Handshake: start is a level request taken on the first IDLE edge where it
// is high; done pulses once per completed run and there is no queueing.
module sc_stream_ctrl
  import sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 3,
  parameter int LEN   = 256,
  parameter int CNT_W = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      seed,
  input  logic [N_IN*WIDTH-1:0] bin_in,
  output logic [N_IN-1:0]       sc_bits,
  output logic                  sc_valid,
  input  logic                  sc_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      result,
  output state_t                state_dbg
);

  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(LEN - 1);

  state_t                state_q, state_d;
  logic [N_IN*WIDTH-1:0] op_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      cyc_q;
  logic [CNT_W-1:0]      result_q;
  logic [CNT_W-1:0]      count_inc;
  logic [WIDTH-1:0]      lfsr_state;
  logic [2*WIDTH-1:0]    lfsr_dbl;
  logic [N_IN-1:0]       cmp_bits;
  logic                  lfsr_load;
  logic                  lfsr_en;
  logic                  last_cyc;

  sc_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .seed  (seed),
    .state (lfsr_state)
  );

  // Rotating left by i is a fixed slice of the doubled LFSR word.
  assign lfsr_dbl = {lfsr_state, lfsr_state};

  for (genvar i = 0; i < N_IN; i++) begin : g_cmp
    assign cmp_bits[i] = lfsr_dbl[2*WIDTH-1-i -: WIDTH] < op_q[i*WIDTH +: WIDTH];
  end

  assign last_cyc  = (cyc_q == LAST_CYC);
  assign count_inc = count_q + CNT_W'(sc_out);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        lfsr_en = 1'b1;
        if (abort)         state_d = IDLE;
        else if (last_cyc) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      op_q     <= '0;
      count_q  <= '0;
      cyc_q    <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        op_q    <= bin_in;
        count_q <= '0;
        cyc_q   <= '0;
      end else if (state_q == RUN) begin
        count_q <= count_inc;
        cyc_q   <= cyc_q + 1'b1;
        // The last stream bit is counted on the same edge that enters DONE,
        // so the result must include it directly.
        if (!abort && last_cyc) result_q <= count_inc;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign sc_valid  = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign sc_bits   = sc_valid ? cmp_bits : '0;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sc_stream_ctrl.sv
module tb_sc_stream_ctrl;

  localparam int WIDTH = 8;
  localparam int N_IN  = 3;
  localparam int LEN   = 256;
  localparam int CNT_W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic [WIDTH-1:0]      seed;
  logic [N_IN*WIDTH-1:0] bin_in;
  logic [N_IN-1:0]       sc_bits;
  logic                  sc_valid;
  logic                  sc_out;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      result;
  sc_pkg::state_t        state_dbg;

  logic [1:0] mode;  // selects the external SC circuit behaviour

  int n_tests = 0;
  int n_fail  = 0;

  sc_stream_ctrl #(.WIDTH(WIDTH), .N_IN(N_IN), .LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .bin_in    (bin_in),
    .sc_bits   (sc_bits),
    .sc_valid  (sc_valid),
    .sc_out    (sc_out),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // External SC circuit: 0 = const 0, 1 = const 1, 2 = wire bit0, 3 = majority.
  function automatic logic sc_fn(input logic [N_IN-1:0] b, input logic [1:0] m);
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return b[0];
      default: return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endcase
  endfunction

  always_comb sc_out = sc_fn(sc_bits, mode);

  // ---------------- reference model ----------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic [7:0] n;
    for (int j = 0; j < 7; j++) n[j] = s[j+1];
    n[7] = s[7] ^ s[6] ^ s[3] ^ s[2] ^ s[1] ^ s[0];
    return n;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] s, input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[(j + k) % 8] = s[j];
    return r;
  endfunction

  logic [N_IN-1:0]  exp_q[$];   // expected sc_bits for each remaining RUN cycle
  logic             m_done   = 1'b0;
  logic [CNT_W-1:0] m_result = '0;
  logic [CNT_W-1:0] m_pending = '0;

  task automatic build_run(input logic [7:0] s, input logic [N_IN*WIDTH-1:0] b);
    logic [7:0]      l;
    logic [N_IN-1:0] v;
    int              ones;
    l    = (s == 8'h00) ? 8'h01 : s;
    ones = 0;
    for (int c = 0; c < LEN; c++) begin
      for (int i = 0; i < N_IN; i++) v[i] = (rotl(l, i) < b[i*WIDTH +: WIDTH]);
      exp_q.push_back(v);
      ones += int'(sc_fn(v, mode));
      l = lfsr_step(l);
    end
    m_pending = CNT_W'(ones);
  endtask

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      exp_q.delete();
      m_done   = 1'b0;
      m_result = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (abort) begin
        exp_q.delete();
      end else begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_done   = 1'b1;
          m_result = m_pending;
        end
      end
    end else if (start) begin
      build_run(seed, bin_in);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic            e_busy;
    logic [N_IN-1:0] e_bits;
    if (!rst_n) begin
      e_busy = (exp_q.size() > 0);
      e_bits = e_busy ? exp_q[0] : '0;
      chk("cyc_busy",     32'(busy),     32'(e_busy));
      chk("cyc_sc_valid", 32'(sc_valid), 32'(e_busy));
      chk("cyc_done",     32'(done),     32'(m_done));
      chk("cyc_result",   32'(result),   32'(m_result));
      chk("cyc_sc_bits",  32'(sc_bits),  32'(e_bits));
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the first RUN cycle's falling edge + 1.
  task automatic launch(input logic [7:0] s, input logic [N_IN*WIDTH-1:0] b,
                        input logic [1:0] m);
    @(negedge clk); #1;
    mode   = m;
    seed   = s;
    bin_in = b;
    start  = 1'b1;
    @(negedge clk); #1;
    start  = 1'b0;
  endtask

  // n counts falling edges since start was raised; ends at done's edge + 1.
  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("done_timeout", 32'(n), 32'(budget));
        break;
      end
    end
    #1;
  endtask

  task automatic count_dones(input int cycles, output int d);
    d = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) d++;
    end
    #1;
  endtask

  int lat, dn, ref_ones;
  logic [7:0] l8;

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    seed = '0; bin_in = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_sc_valid", 32'(sc_valid), 32'd0);
    chk("rst_result",   32'(result),   32'd0);
    chk("rst_sc_bits",  32'(sc_bits),  32'd0);
    #1 rst_n = 1'b0;

    // LFSR sequence 0x01, 0x80, 0xC0 against operand0 = 0x81
    launch(8'h01, {8'h00, 8'h00, 8'h81}, 2'd2);
    chk("lfsr_c1_bit0", 32'(sc_bits[0]), 32'd1);
    @(negedge clk); #1;
    chk("lfsr_c2_bit0", 32'(sc_bits[0]), 32'd1);
    @(negedge clk); #1;
    chk("lfsr_c3_bit0", 32'(sc_bits[0]), 32'd0);
    wait_done(3, 400, lat);
    chk("lfsr_latency", 32'(lat), 32'd257);

    // zero operands, loopback
    launch(8'h37, '0, 2'd2);
    wait_done(1, 400, lat);
    chk("zero_latency", 32'(lat),    32'd257);
    chk("zero_result",  32'(result), 32'd0);

    // all-ones circuit output
    launch(8'h37, {8'h12, 8'h34, 8'h56}, 2'd1);
    wait_done(1, 400, lat);
    chk("ones_result", 32'(result), 32'd256);

    // operand 0xFF: count of RUN-cycle LFSR states other than 0xFF
    ref_ones = 0;
    l8 = 8'h01;
    for (int c = 0; c < LEN; c++) begin
      if (l8 != 8'hFF) ref_ones++;
      l8 = lfsr_step(l8);
    end
    launch(8'h01, {8'hFF, 8'hFF, 8'hFF}, 2'd2);
    wait_done(1, 400, lat);
    chk("ff_seed1_result", 32'(result), 32'(ref_ones));
    launch(8'h00, {8'hFF, 8'hFF, 8'hFF}, 2'd2);
    wait_done(1, 400, lat);
    chk("ff_seed0_result", 32'(result), 32'(ref_ones));

    // majority of three decorrelated streams
    launch(8'h5A, {8'hC8, 8'h90, 8'h40}, 2'd3);
    wait_done(1, 400, lat);
    chk("maj_latency", 32'(lat), 32'd257);

    // start held high across two full runs
    @(negedge clk); #1;
    mode = 2'd2; seed = 8'hA5; bin_in = {8'h80, 8'h80, 8'h80};
    start = 1'b1;
    count_dones(2 * (LEN + 2), dn);
    start = 1'b0;
    chk("cont_start_dones", 32'(dn), 32'd2);
    count_dones(5, dn);
    chk("cont_start_idle", 32'(dn), 32'd0);

    // second start mid-run must not restart
    launch(8'h11, {8'h20, 8'hE0, 8'h70}, 2'd3);
    repeat (49) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(51, 400, lat);
    chk("restart_latency", 32'(lat), 32'd257);

    // abort at RUN cycle 10 keeps the previous result
    launch(8'h01, '0, 2'd1);
    wait_done(1, 400, lat);
    launch(8'h22, {8'h40, 8'h40, 8'h40}, 2'd0);
    repeat (9) @(negedge clk);
    #1 abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    count_dones(300, dn);
    chk("abort_no_done", 32'(dn),     32'd0);
    chk("abort_result",  32'(result), 32'd256);

    // start with abort in IDLE: start wins
    @(negedge clk); #1;
    abort = 1'b1;
    launch(8'h01, {8'h10, 8'h10, 8'h10}, 2'd1);
    abort = 1'b0;
    wait_done(1, 400, lat);
    chk("abort_idle_latency", 32'(lat),    32'd257);
    chk("abort_idle_result",  32'(result), 32'd256);

    // asynchronous reset mid-run
    launch(8'h33, {8'h90, 8'h90, 8'h90}, 2'd1);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_sc_valid", 32'(sc_valid), 32'd0);
    chk("arst_result",   32'(result),   32'd0);
    chk("arst_done",     32'(done),     32'd0);
    @(negedge clk); #1 rst_n = 1'b0;
    launch(8'h33, {8'h90, 8'h90, 8'h90}, 2'd1);
    wait_done(1, 400, lat);
    chk("arst_rerun_latency", 32'(lat),    32'd257);
    chk("arst_rerun_result",  32'(result), 32'd256);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sc_stream_ctrl.md
Name: sc_stream_ctrl

Overview:
- Sequences one stochastic-computing (SC) evaluation.
- Seeds and steps an 8-bit LFSR, and converts N_IN latched binary operands into stochastic bitstreams using per-input comparators.
- Drives those bits into the external combinational SC circuit for LEN cycles, counts the ones on its output bit, and returns the count as a binary result.
- Sits between the host/test logic and the SC circuit; start/done handshake.

Parameters:
- WIDTH, 8, LFSR, operand and comparator width (polynomial below is defined for 8 only).
- N_IN, 3, number of stochastic inputs generated (1..WIDTH).
- LEN, 256, bitstream length in cycles (1..65535).
- CNT_W, 17, result/counter width; must hold LEN (≥ clog2(LEN+1)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-high: rst_n=1 resets. The name is kept for consistency with the codebase.
- start  in  1  request a run. Sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- seed  in  WIDTH  LFSR seed, latched at start.
- bin_in  in  N_IN*WIDTH  operands; slice i is operand i, latched at start.
- sc_bits  out  N_IN  stochastic bits to the SC circuit.
- sc_valid  out  1  high while sc_bits are part of the counted stream.
- sc_out  in  1  SC circuit output bit. Combinational from sc_bits, same cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result valid from this cycle on.
- result  out  CNT_W  number of ones observed on sc_out during the last completed run.

Behaviour:
- Reset (async, rst_n=1) sets:
  - state=IDLE, lfsr=8'h01, count=0, result=0.
  - busy=0, done=0, sc_valid=0.
  - operand regs=0.
- sc_bits are 0 whenever sc_valid=0 (gated).
- LFSR step: next[i]=s[i+1] for i=0..6; next[7]=s7^s6^s3^s2^s1^s0.
- Seed handling: a seed of 0 is replaced by 8'h01 so the LFSR cannot lock at zero.
- Comparator, for each input i: sc_bits[i] = (rotl(lfsr, i) < operand_i), unsigned.
  - Input i uses the LFSR state rotated left by i bits, which decorrelates the streams.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch operands, lfsr<=seed (or 8'h01 if seed=0), count<=0, cycle counter<=0, go to RUN.
  - done is cleared at this edge.
- RUN (cycles k+1 .. k+LEN):
  - sc_valid=1 and busy=1.
  - Each edge: count += sc_out, the LFSR steps, and the cycle counter increments.
  - After the LEN-th RUN cycle, go to DONE.
- DONE (exactly one cycle):
  - result<=count at entry, so result is visible with done=1; done=1 for this cycle.
  - Then go to IDLE. result holds until the next DONE.
- Latency: start edge k → done high in cycle k+LEN+1.
- start while RUN or DONE is ignored; there is no queueing.
- abort=1 in RUN: next edge goes to IDLE, busy=0, no done pulse, result unchanged.
- abort and start together in IDLE: start wins; abort has no effect in IDLE or DONE.
- Counter saturation is impossible by construction (count ≤ LEN ≤ 2^CNT_W−1).
- Asynchronous reset during RUN returns to the reset values immediately; no done pulse.

Decomposition:
- Package sc_pkg holds:
  - the LFSR width, the tap mask constant 8'hCF (bits 7,6,3,2,1,0), and the zero-seed substitute 8'h01;
  - the state enum {IDLE, RUN, DONE}.
- One sub-module: sc_lfsr8 (load/enable/seed, exposes state).
- Comparators and the counter stay inline.

Test Plan:
- LFSR sequence: seed=8'h01, start → lfsr 0x01 in first RUN cycle, then 0x80, then 0xC0. With operand0=0x81, sc_bits[0] = 1, 1, 0 over those cycles.
- All-zero operands, sc_out looped to sc_bits[0], LEN=256 → done at start+257, result=0. All-ones sc_out → result=256.
- Operand 0xFF, seed 0x01, loopback on sc_bits[0] → result equals the number of RUN-cycle LFSR states ≠ 0xFF; check against a reference model. A seed of 0 gives the same result as seed 0x01.
- start asserted continuously through a run → exactly one done per run, then a new run begins on the first IDLE cycle. A second start pulse mid-RUN causes no restart: done at original time.
- abort at RUN cycle 10 → busy drops next edge, no done, result keeps the prior value (e.g. 256).
- rst_n=1 pulse mid-RUN (async, between edges) → busy, sc_valid, result, done all 0 immediately. The next start runs a full LEN cycles.
